// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. Two WIDTH-bit operands are latched on
// start and fed LSB first, one bit pair per clock, through a single full adder
// built from two half adders and a carry flop. The registered sum/cout are
// updated only when the last bit has been processed.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [1:0]       ha0, ha1;
  logic             fa_sum, fa_carry;
  logic [WIDTH-1:0] res_shift;

  // Half adder cell: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full adder from two half adders on the current LSB pair and the carry flop.
  always_comb begin
    ha0      = half_add(a_sh_q[0], b_sh_q[0]);
    ha1      = half_add(ha0[0], carry_q);
    fa_sum   = ha1[0];
    fa_carry = ha0[1] | ha1[1];
  end

  // Result register with the new sum bit entering at the MSB; a 1-bit result
  // has nothing to shift down, so it is just the sum bit.
  if (WIDTH == 1) begin : g_res_w1
    assign res_shift = fa_sum;
  end else begin : g_res_wn
    assign res_shift = {fa_sum, res_q[WIDTH-1:1]};
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d   = res_shift;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_carry;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          sum_d   = res_shift;
          cout_d  = fa_carry;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything and aborts a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random additions on WIDTH=8, 1 and 16 instances,
// compared against plain a+b arithmetic with cycle-exact handshake timing.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        s8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        s1, busy1, done1, cout1;
  logic [0:0]  a1, b1, sum1;
  logic        s16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  int total = 0;
  int bad   = 0;

  logic [7:0] last8;
  logic       lastc8;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 addition. noise: wiggle start/a/b while busy.
  // b2b: return in the DONE cycle so the next call starts back-to-back.
  task automatic add8(input logic [7:0] x, input logic [7:0] y, input bit noise, input bit b2b);
    logic [8:0] r;
    r  = {1'b0, x} + {1'b0, y};
    s8 = 1'b1; a8 = x; b8 = y;
    tick;
    s8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("busy8_run", busy8, 1);
      chk("done8_early", done8, 0);
      chk("sum8_hold", sum8, last8);
      chk("cout8_hold", cout8, lastc8);
      if (noise) begin
        if (i == 0) begin
          s8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        end else begin
          s8 = 1'($urandom_range(0, 1)); a8 = 8'($urandom); b8 = 8'($urandom);
        end
      end
      tick;
    end
    s8 = 1'b0;
    chk("busy8_done", busy8, 0);
    chk("done8_pulse", done8, 1);
    chk("sum8", sum8, r[7:0]);
    chk("cout8", cout8, r[8]);
    last8  = r[7:0];
    lastc8 = r[8];
    if (!b2b) begin
      tick;
      chk("done8_one_cycle", done8, 0);
      chk("busy8_idle", busy8, 0);
      chk("sum8_kept", sum8, r[7:0]);
    end
  endtask

  task automatic add1(input logic x, input logic y);
    logic [1:0] r;
    r  = {1'b0, x} + {1'b0, y};
    s1 = 1'b1; a1 = x; b1 = y;
    tick;
    s1 = 1'b0;
    chk("busy1_run", busy1, 1);
    chk("done1_early", done1, 0);
    tick;
    chk("done1_pulse", done1, 1);
    chk("busy1_done", busy1, 0);
    chk("sum1", sum1, r[0]);
    chk("cout1", cout1, r[1]);
    tick;
    chk("done1_one_cycle", done1, 0);
  endtask

  task automatic add16(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] r;
    r   = {1'b0, x} + {1'b0, y};
    s16 = 1'b1; a16 = x; b16 = y;
    tick;
    s16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("busy16_run", busy16, 1);
      chk("done16_early", done16, 0);
      tick;
    end
    chk("done16_pulse", done16, 1);
    chk("busy16_done", busy16, 0);
    chk("sum16", sum16, r[15:0]);
    chk("cout16", cout16, r[16]);
    tick;
    chk("done16_one_cycle", done16, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    s8 = 1'b0;  a8 = '0;  b8 = '0;
    s1 = 1'b0;  a1 = '0;  b1 = '0;
    s16 = 1'b0; a16 = '0; b16 = '0;
    last8 = '0; lastc8 = 1'b0;
    #1;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_cout8", cout8, 0);
    chk("rst_busy16", busy16, 0);
    chk("rst_sum1", sum1, 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    // Basic and directed sums.
    add8(8'h00, 8'h00, 1'b0, 1'b0);
    add8(8'h5A, 8'h25, 1'b0, 1'b0);
    add8(8'hFF, 8'h01, 1'b0, 1'b0);
    add8(8'hFF, 8'hFF, 1'b0, 1'b0);

    // Start and operand changes while busy must be ignored.
    add8(8'h3C, 8'h4B, 1'b1, 1'b0);

    // Back-to-back start in the DONE cycle.
    add8(8'h12, 8'h34, 1'b0, 1'b1);
    add8(8'h80, 8'h80, 1'b0, 1'b0);

    // Random operands, some with noise while busy.
    for (int i = 0; i < 8; i++)
      add8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    // Asynchronous reset in the middle of a run.
    s8 = 1'b1; a8 = 8'hC3; b8 = 8'h5A;
    tick;
    s8 = 1'b0;
    tick; tick; tick;
    chk("busy8_before_abort", busy8, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy8", busy8, 0);
    chk("abort_done8", done8, 0);
    chk("abort_sum8", sum8, 0);
    chk("abort_cout8", cout8, 0);
    last8 = '0; lastc8 = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("abort_no_done8", done8, 0);
      chk("abort_no_busy8", busy8, 0);
      tick;
    end
    add8(8'h01, 8'h02, 1'b0, 1'b0);

    // WIDTH=1: every operand combination.
    add1(1'b1, 1'b1);
    add1(1'b0, 1'b0);
    add1(1'b1, 1'b0);
    add1(1'b0, 1'b1);

    // WIDTH=16: wrap-around case and random operands.
    add16(16'hFFFF, 16'h0001);
    for (int i = 0; i < 3; i++)
      add16(16'($urandom), 16'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
